// File: rtl/sync_fifo_2048x8_pkg.sv
// Shared sizing and types for the 2048x8 FIFO controller and its RAM core.
package sync_fifo_2048x8_pkg;

    localparam int DEPTH  = 2048;
    localparam int ADDR_W = 11;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 12;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [CNT_W-1:0]  cnt_t;

endpackage

// File: rtl/dual_port_sram.sv
// Simple dual-port RAM primitive: one write port, one registered read port.
module dual_port_sram
    import sync_fifo_2048x8_pkg::*;
#(
    parameter int AW = ADDR_W,
    parameter int DW = DATA_W
) (
    input  logic          wclk,
    input  logic          wen,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          rclk,
    input  logic          ren,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    // NOTE: storage arrays get no reset; clearing 2K words is not a RAM operation
    // and would stop the array mapping onto the macro.
    always_ff @(posedge wclk) begin
        if (wen) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge rclk) begin
        if (ren) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo_2048x8.sv
// Single-clock FIFO controller around dual_port_sram: pointers, occupancy,
// level flags and sticky overflow/underflow errors.
module sync_fifo_2048x8
    import sync_fifo_2048x8_pkg::*;
#(
    parameter int AFULL_THRESH  = 2040,
    parameter int AEMPTY_THRESH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] data_in,
    input  logic              pop,
    output logic [DATA_W-1:0] data_out,
    output logic              dout_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_err
);

    addr_t wptr;
    addr_t rptr;
    data_t rdata;
    logic  push_ok;
    logic  pop_ok;

    // Flags decode only from the registered count, never from push/pop.
    assign full         = (count == cnt_t'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= cnt_t'(AFULL_THRESH));
    assign almost_empty = (count <= cnt_t'(AEMPTY_THRESH));

    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // Gate the RAM register so stale words never leak out between reads.
    assign data_out = dout_valid ? rdata : '0;

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop_ok)  rptr <= rptr + 1'b1;
            dout_valid <= pop_ok;

            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            // A fresh error in the clearing cycle keeps the flag set.
            if (push && full)  overflow <= 1'b1;
            else if (clr_err)  overflow <= 1'b0;

            if (pop && empty)  underflow <= 1'b1;
            else if (clr_err)  underflow <= 1'b0;
        end
    end

    dual_port_sram #(
        .AW (ADDR_W),
        .DW (DATA_W)
    ) u_ram (
        .wclk  (clk),
        .wen   (push_ok),
        .waddr (wptr),
        .wdata (data_in),
        .rclk  (clk),
        .ren   (pop_ok),
        .raddr (rptr),
        .rdata (rdata)
    );

endmodule
